regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the CPU datapath: a configurable number of combinational read ports, two synchronous write ports with fixed priority, and an optional hardwired zero register. A built-in dump engine streams every register over a valid/ready handshake, so a testbench or debug UART can read architectural state without stopping the core.

## Interface
- DATA_WIDTH, 32, register width in bits
- REGADDR_WIDTH, 5, address width; NUM_REGS = 2**REGADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = r0 reads 0 and ignores writes; 0 = r0 is an ordinary register

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and the dump engine
- rd_addr  in  NUM_READ*REGADDR_WIDTH  packed read addresses; port i = bits [i*REGADDR_WIDTH +: REGADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- wa_en, wa_addr, wa_data  in  1 / REGADDR_WIDTH / DATA_WIDTH  write port A
- wb_en, wb_addr, wb_data  in  1 / REGADDR_WIDTH / DATA_WIDTH  write port B (higher priority)
- dump_start  in  1  request a full dump; sampled only in IDLE
- dump_busy  out  1  engine in SEND or DONE
- dump_valid  out  1  dump_addr/dump_data hold a valid beat
- dump_ready  in  1  consumer accepts the current beat
- dump_addr  out  REGADDR_WIDTH  register index of current beat
- dump_data  out  DATA_WIDTH  register contents of current beat
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Writes: on rising edge, wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr. Both enabled to the same address: port B value is stored.
- ZERO_REG=1: writes to address 0 on either port are discarded; every read of address 0 (read ports and dump) returns 0.
- Reads: rd_data port i = regs[rd_addr i], combinational.
- Dump FSM states IDLE, SEND, DONE:
  - IDLE: dump_start=1 -> SEND; dump_addr<=0; dump_data<=regs[0]; dump_valid<=1.
  - SEND: dump_valid && dump_ready with dump_addr < NUM_REGS-1 -> dump_addr+1, dump_data<=regs[dump_addr+1]; with dump_addr = NUM_REGS-1 -> DONE, dump_valid<=0. No handshake: all dump outputs hold.
  - DONE: dump_done=1 for one cycle -> IDLE.
- dump_data is captured from stored contents at the loading edge (pre-write value if that register is written on the same edge); later writes to already-sent registers are not reflected.
- dump_start outside IDLE is ignored. Writes and reads proceed normally during a dump.
- dump_addr wraps are impossible; counter stops at NUM_REGS-1.

## Timing
- Reset (asynchronous assert): all registers 0; FSM IDLE; dump_busy, dump_valid, dump_done, dump_addr, dump_data all 0. rd_data reflects cleared registers immediately.
- Reset mid-dump: dump aborts immediately, no dump_done pulse.
- Read latency 0 cycles; write visible on rd_data the cycle after the write edge (without bypass).
- Dump with dump_ready held 1: start sampled at edge k; beats at cycles k+1..k+NUM_REGS; dump_done in cycle k+NUM_REGS+1; dump_busy high cycles k+1..k+NUM_REGS+1; next dump_start accepted at edge k+NUM_REGS+2.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding on read ports; if wb_en && wb_addr==rd_addr i, rd_data i = wb_data; else if wa_en && wa_addr==rd_addr i, rd_data i = wa_data; else stored value. Address 0 with ZERO_REG=1 still returns 0. Dump path never bypasses.
- Not defined: read ports return stored contents only; same-cycle writes appear next cycle.

## Test plan
- Reset then read all addresses on both ports -> all 0; assert reset mid-dump at beat 5 -> dump_valid/busy 0 same cycle, no dump_done.
- wa writes 0x1111_1111 and wb writes 0x2222_2222 to r7 same edge -> r7 reads 0x2222_2222; write 0xDEAD_BEEF to r0 with ZERO_REG=1 -> r0 reads 0.
- With REGFILE_BYPASS_EN, wa_en=1 wa_addr=3 wa_data=0x55 while rd_addr port1=3 -> rd_data port1=0x55 same cycle; without macro -> old value, 0x55 next cycle.
- Load rN=N+100 for N=1..31, pulse dump_start, dump_ready=1 -> 32 beats addr 0..31 data 0,101..131, dump_done one cycle after beat 31, busy 33 cycles.
- Dump with dump_ready toggling 1/0 each cycle -> beats held stable while ready=0, no beat skipped or duplicated; dump_start pulsed mid-dump -> ignored.
- During dump, write r20=0xABCD at beat 10 -> beat 20 shows 0xABCD; write r5=0xABCD at beat 10 -> beat 5 kept original value.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports and a valid/ready dump engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int NUM_READ      = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_READ*REGADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    input  logic                              wa_en,
    input  logic [REGADDR_WIDTH-1:0]          wa_addr,
    input  logic [DATA_WIDTH-1:0]             wa_data,
    input  logic                              wb_en,
    input  logic [REGADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]             wb_data,
    input  logic                              dump_start,
    output logic                              dump_busy,
    output logic                              dump_valid,
    input  logic                              dump_ready,
    output logic [REGADDR_WIDTH-1:0]          dump_addr,
    output logic [DATA_WIDTH-1:0]             dump_data,
    output logic                              dump_done
);
    localparam int NUM_REGS = 1 << REGADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];
    state_t                   state_q, state_d;
    logic [REGADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_WIDTH-1:0]    dump_data_q, dump_data_d;
    logic                     dump_valid_q, dump_valid_d;

    // Port B is applied last so it wins a same-address collision; r0 is re-cleared when hardwired.
    always_comb begin
        regs_d = regs_q;
        if (wa_en) regs_d[wa_addr] = wa_data;
        if (wb_en) regs_d[wb_addr] = wb_data;
        if (ZERO_REG != 0) regs_d[0] = '0;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [REGADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0]    v;
        always_comb begin
            a = rd_addr[i*REGADDR_WIDTH +: REGADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            v = (wb_en && wb_addr == a) ? wb_data : (wa_en && wa_addr == a) ? wa_data : regs_q[a];
`else
            v = regs_q[a];
`endif
            if (ZERO_REG != 0 && a == '0) v = '0;
        end
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = v;
    end

    // Dump beats are sampled from stored contents, never from in-flight writes.
    always_comb begin
        state_d      = state_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        case (state_q)
            IDLE: if (dump_start) begin
                state_d      = SEND;
                dump_addr_d  = '0;
                dump_data_d  = regs_q[0];
                dump_valid_d = 1'b1;
            end
            SEND: if (dump_valid_q && dump_ready) begin
                if (dump_addr_q == '1) begin
                    state_d      = DONE;
                    dump_valid_d = 1'b0;
                end else begin
                    dump_addr_d = dump_addr_q + 1'b1;
                    dump_data_d = regs_q[dump_addr_d];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q       <= '{default: '0};
            state_q      <= IDLE;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            state_q      <= state_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign dump_busy  = state_q != IDLE;
    assign dump_done  = state_q == DONE;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters, either bypass build).
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        wa_en = 1'b0, wb_en = 1'b0;
    logic [4:0]  wa_addr = '0, wb_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic        dump_start = 1'b0, dump_ready = 1'b0;
    logic        dump_busy, dump_valid, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    int          n_vec = 0, n_err = 0;
    logic [31:0] model [32];

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int port, input logic [4:0] a, input logic [31:0] exp);
        rd_addr[port*5 +: 5] = a;
        #1;
        check(tag, rd_data[port*32 +: 32], exp);
    endtask

    task automatic wr(input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                      input logic be, input logic [4:0] ba, input logic [31:0] bd);
        @(negedge clk);
        wa_en = ae; wa_addr = aa; wa_data = ad;
        wb_en = be; wb_addr = ba; wb_data = bd;
        @(negedge clk);
        wa_en = 1'b0; wb_en = 1'b0;
        if (ae && aa != 0) model[aa] = ad;
        if (be && ba != 0) model[ba] = bd;
    endtask

    task automatic run_dump(input bit toggle, input bit mid_wr);
        int  idx = 0, busy = 0;
        bit  done_seen = 0;
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            @(negedge clk);
            wa_en = 1'b0; wb_en = 1'b0;
            dump_start = toggle && cyc == 7;
            dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (dump_busy) busy++;
            if (dump_done) begin
                done_seen = 1;
                check("done_after_last", idx, 32);
                check("valid_in_done", dump_valid, 0);
            end else if (dump_valid) begin
                check("dump_addr", dump_addr, idx[4:0]);
                check($sformatf("dump_data_r%0d", idx), dump_data, model[idx]);
                if (mid_wr && dump_ready && idx == 10) begin
                    wa_en = 1'b1; wa_addr = 5'd20; wa_data = 32'hABCD;
                    wb_en = 1'b1; wb_addr = 5'd5;  wb_data = 32'hABCD;
                    model[20] = 32'hABCD;
                    model[5]  = 32'hABCD;
                end
                if (dump_ready) idx++;
            end
        end
        check("dump_done_seen", done_seen, 1);
        check("busy_cycles", busy, toggle ? 64 : 33);
        @(negedge clk);
        wa_en = 1'b0; wb_en = 1'b0; dump_start = 1'b0;
        #1;
        check("idle_busy", dump_busy, 0);
        check("idle_done", dump_done, 0);
        @(negedge clk);
        #1;
        check("still_idle", dump_busy, 0);
    endtask

    initial begin
        int done_cnt, guard;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #12;
        for (int a = 0; a < 32; a++) begin
            rd_chk("rst_rd0", 0, a[4:0], 0);
            rd_chk("rst_rd1", 1, a[4:0], 0);
        end
        check("rst_busy", dump_busy, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_done", dump_done, 0);
        check("rst_daddr", dump_addr, 0);
        check("rst_ddata", dump_data, 0);
        @(negedge clk);
        reset = 1'b0;

        wr(1, 5'd7, 32'h1111_1111, 1, 5'd7, 32'h2222_2222);
        rd_chk("prio_r7", 0, 5'd7, 32'h2222_2222);
        wr(1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 32'hDEAD_BEEF);
        rd_chk("zero_r0", 1, 5'd0, 0);

        @(negedge clk);
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h55;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h77;
        rd_addr[9:5] = 5'd3;
        rd_addr[4:0] = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", rd_data[63:32], 32'h55);
`else
        check("byp_same", rd_data[63:32], 32'h0);
`endif
        check("byp_r0", rd_data[31:0], 0);
        @(negedge clk);
        wa_en = 1'b0; wb_en = 1'b0;
        model[3] = 32'h55;
        #1;
        check("byp_next", rd_data[63:32], 32'h55);

        for (int n = 1; n < 32; n++) wr(1, n[4:0], n + 100, 0, 5'd0, 0);
        rd_chk("load_r31", 0, 5'd31, 131);
        rd_chk("load_r1", 1, 5'd1, 101);

        run_dump(0, 0);
        run_dump(1, 0);
        run_dump(0, 1);
        rd_chk("post_r5", 0, 5'd5, 32'hABCD);
        rd_chk("post_r20", 1, 5'd20, 32'hABCD);

        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        guard = 0;
        #1;
        while (!(dump_valid && dump_addr == 5'd5) && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reach_beat5", guard < 50, 1);
        reset = 1'b1;
        #1;
        check("abort_valid", dump_valid, 0);
        check("abort_busy", dump_busy, 0);
        rd_chk("abort_rd", 0, 5'd7, 0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dump_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_daddr", dump_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
